// File: rtl/pipe_issue_unit.sv
// pipe_issue_unit
// ---------------------------------------------------------------------------
// Fetch/issue stage in front of the 4-stage register/ALU/memory pipeline.
// It buffers 24-bit instruction words from a loader in a small FIFO. Each
// cycle it decodes at most one word onto a registered operand bus. Because
// the pipeline has no forwarding, it inserts NOP bubbles on read-after-write
// hazards. Issuing stops on a HALT word (func = 15), which is consumed but
// never issued.
//
// Optional feature macro: PIPE_HAZARD_CHECK_EN
//   defined     -> RAW hazard detection and bubble insertion; STALL reachable
//   not defined -> no hazard comparison; stall_cnt stays 0. Software must
//                  place dependent instructions HAZ_WIN slots apart.
//
// Parameters
//   DEPTH    FIFO entries (power of two)
//   HAZ_WIN  number of previously issued slots checked for hazards (1..3)
//   NOP_REG  scratch register used by bubbles; never a hazard source
//   NOP_ADDR scratch memory address written by bubbles
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   start        pulse: leave IDLE/HALT and begin issuing
//   ld_valid     loader word valid
//   ld_data      word {func[23:20], rs1[19:16], rs2[15:12], rd[11:8], addr[7:0]}
//   ld_ready     FIFO not full
//   rs1/rs2/rd/func/addr  registered operand bus
//   issue_valid  bus holds a real instruction (0 = bubble)
//   busy         state is RUN or STALL
//   halted       HALT consumed; cleared by start or reset
//   issue_cnt    real instructions issued (wraps)
//   stall_cnt    hazard bubbles inserted (wraps)
// ---------------------------------------------------------------------------
module pipe_issue_unit #(
  parameter int         DEPTH    = 16,
  parameter int         HAZ_WIN  = 2,
  parameter logic [3:0] NOP_REG  = 4'd15,
  parameter logic [7:0] NOP_ADDR = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ld_valid,
  input  logic [23:0] ld_data,
  output logic        ld_ready,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [3:0]  rd,
  output logic [3:0]  func,
  output logic [7:0]  addr,
  output logic        issue_valid,
  output logic        busy,
  output logic        halted,
  output logic [15:0] issue_cnt,
  output logic [15:0] stall_cnt
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [3:0] NOP_FUNC  = 4'd3;
  localparam logic [3:0] HALT_FUNC = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL, S_HALT} state_t;

  state_t state_reg, state_next;

  // ---------------- instruction FIFO ----------------
  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [23:0] fifo_mem [DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic        fifo_full, fifo_empty, push, do_pop;
  logic [23:0] head;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  // ld_ready depends only on full; a pop in the same cycle does not make room.
  assign ld_ready   = !fifo_full;
  assign push       = ld_valid && !fifo_full;
  // The head is read combinationally so a word pushed at edge t can issue at t+1.
  assign head       = fifo_mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg[AW-1:0]] <= ld_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push)   wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  logic [3:0] head_func, head_rs1, head_rs2, head_rd;
  logic [7:0] head_addr;
  assign {head_func, head_rs1, head_rs2, head_rd, head_addr} = head;

  // ---------------- issue history ----------------
  // Slot 0 is the most recently issued slot. Every cycle shifts in one entry.
  // Bubbles and idle cycles enter as invalid entries.
  logic                do_issue, do_stall, hazard;
  logic [HAZ_WIN-1:0]  haz_hit;

  genvar gi;
  generate
    for (gi = 0; gi < HAZ_WIN; gi++) begin : g_hist
      logic [3:0] rd_q;
      logic       vld_q;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            rd_q  <= NOP_REG;
            vld_q <= 1'b0;
          end else begin
            rd_q  <= do_issue ? head_rd : NOP_REG;
            vld_q <= do_issue;
          end
        end
      end else begin : g_next
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            rd_q  <= NOP_REG;
            vld_q <= 1'b0;
          end else begin
            rd_q  <= g_hist[gi-1].rd_q;
            vld_q <= g_hist[gi-1].vld_q;
          end
        end
      end
      // Reading the scratch register never creates a dependency.
      assign haz_hit[gi] = vld_q &&
                           ((head_rs1 != NOP_REG && head_rs1 == rd_q) ||
                            (head_rs2 != NOP_REG && head_rs2 == rd_q));
    end
  endgenerate

`ifdef PIPE_HAZARD_CHECK_EN
  assign hazard = |haz_hit;
`else
  assign hazard = 1'b0;
  logic unused_cfg;
  assign unused_cfg = ^{haz_hit, do_stall};
`endif

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    do_pop     = 1'b0;
    do_issue   = 1'b0;
    do_stall   = 1'b0;
    case (state_reg)
      S_IDLE, S_HALT: begin
        if (start) state_next = S_RUN;
      end
      S_RUN, S_STALL: begin
        if (fifo_empty) begin
          state_next = S_RUN;
        end else if (head_func == HALT_FUNC) begin
          do_pop     = 1'b1;
          state_next = S_HALT;
        end else if (hazard) begin
          do_stall   = 1'b1;
          state_next = S_STALL;
        end else begin
          do_pop     = 1'b1;
          do_issue   = 1'b1;
          state_next = S_RUN;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy   = (state_reg == S_RUN) || (state_reg == S_STALL);
  assign halted = (state_reg == S_HALT);

  // ---------------- registered operand bus and counters ----------------
  logic [3:0]  func_reg, rs1_reg, rs2_reg, rd_reg;
  logic [7:0]  addr_reg;
  logic        issue_valid_reg;
  logic [15:0] issue_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      func_reg        <= NOP_FUNC;
      rs1_reg         <= NOP_REG;
      rs2_reg         <= NOP_REG;
      rd_reg          <= NOP_REG;
      addr_reg        <= NOP_ADDR;
      issue_valid_reg <= 1'b0;
      issue_cnt_reg   <= '0;
    end else begin
      issue_valid_reg <= do_issue;
      if (do_issue) begin
        {func_reg, rs1_reg, rs2_reg, rd_reg, addr_reg} <= head;
        issue_cnt_reg <= issue_cnt_reg + 16'd1;
      end else begin
        func_reg <= NOP_FUNC;
        rs1_reg  <= NOP_REG;
        rs2_reg  <= NOP_REG;
        rd_reg   <= NOP_REG;
        addr_reg <= NOP_ADDR;
      end
    end
  end

`ifdef PIPE_HAZARD_CHECK_EN
  logic [15:0] stall_cnt_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           stall_cnt_reg <= '0;
    else if (do_stall) stall_cnt_reg <= stall_cnt_reg + 16'd1;
  end
  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = 16'd0;
`endif

  assign func        = func_reg;
  assign rs1         = rs1_reg;
  assign rs2         = rs2_reg;
  assign rd          = rd_reg;
  assign addr        = addr_reg;
  assign issue_valid = issue_valid_reg;
  assign issue_cnt   = issue_cnt_reg;

endmodule

// File: tb/tb_pipe_issue_unit.sv
// Testbench for pipe_issue_unit: directed vectors with hand-computed results.
module tb_pipe_issue_unit;

  logic        clk, rst, start, ld_valid;
  logic [23:0] ld_data;
  logic        ld_ready, issue_valid, busy, halted;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr;
  logic [15:0] issue_cnt, stall_cnt;

  int check_cnt = 0;
  int pass_cnt  = 0;

`ifdef PIPE_HAZARD_CHECK_EN
  localparam int EXP_B_ADJ = 2;  // producer immediately followed by consumer
  localparam int EXP_B_GAP = 1;  // one independent instruction in between
`else
  localparam int EXP_B_ADJ = 0;
  localparam int EXP_B_GAP = 0;
`endif

  pipe_issue_unit dut (
    .clk(clk), .rst(rst), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
    .issue_valid(issue_valid), .busy(busy), .halted(halted),
    .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] enc(input logic [3:0] f, a, b, d, input logic [7:0] ad);
    return {f, a, b, d, ad};
  endfunction

  localparam logic [23:0] NOP_BUS = {4'd3, 4'd15, 4'd15, 4'd15, 8'd255};

  logic [23:0] bus;
  assign bus = {func, rs1, rs2, rd, addr};

  // All driving and sampling happens on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; ld_valid = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_word(input logic [23:0] w);
    ld_valid = 1'b1; ld_data = w;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for the next real issue; counts bubble cycles seen on the way.
  task automatic wait_issue(input int max, output int bubbles, output bit ok);
    bubbles = 0; ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (issue_valid === 1'b1) begin ok = 1'b1; break; end
      bubbles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check_cnt++; if (bus !== NOP_BUS) $display("FAIL reset_bus: got %h want %h", bus, NOP_BUS); else pass_cnt++;
    check_cnt++; if ({issue_valid, busy, halted, ld_ready} !== 4'b0001) $display("FAIL reset_flags: got %b want 0001", {issue_valid, busy, halted, ld_ready}); else pass_cnt++;
    check_cnt++; if ({issue_cnt, stall_cnt} !== 32'd0) $display("FAIL reset_counters: got %0d/%0d want 0/0", issue_cnt, stall_cnt); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    // Mid-stream reset: 5 words buffered, one issued, then asynchronous reset.
    for (int i = 0; i < 5; i++) push_word(enc(4'd0, 4'd1, 4'd2, 4'd3, 8'(i)));
    pulse_start();
    tick();
    check_cnt++; if (issue_valid !== 1'b1 || bus !== enc(4'd0, 4'd1, 4'd2, 4'd3, 8'd0)) $display("FAIL pre_reset_issue: got v=%b bus=%h want v=1 bus=%h", issue_valid, bus, enc(4'd0, 4'd1, 4'd2, 4'd3, 8'd0)); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    check_cnt++; if (bus !== NOP_BUS || issue_valid !== 1'b0) $display("FAIL async_reset_bus: got v=%b bus=%h want v=0 bus=%h", issue_valid, bus, NOP_BUS); else pass_cnt++;
    check_cnt++; if ({issue_cnt, stall_cnt} !== 32'd0 || ld_ready !== 1'b1 || busy !== 1'b0) $display("FAIL async_reset_state: got cnt=%0d stall=%0d rdy=%b busy=%b want 0 0 1 0", issue_cnt, stall_cnt, ld_ready, busy); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    // Buffered words must be gone: running with nothing loaded issues nothing.
    pulse_start();
    tick(); tick();
    check_cnt++; if (issue_valid !== 1'b0 || busy !== 1'b1 || issue_cnt !== 16'd0) $display("FAIL fifo_flushed: got v=%b busy=%b cnt=%0d want 0 1 0", issue_valid, busy, issue_cnt); else pass_cnt++;
  endtask

  task automatic test_independent();
    logic [23:0] w [3];
    w[0] = enc(4'd0, 4'd3, 4'd5, 4'd10, 8'h10);
    w[1] = enc(4'd2, 4'd8, 4'd6, 4'd11, 8'h20);
    w[2] = enc(4'd1, 4'd1, 4'd4, 4'd12, 8'h30);
    do_reset();
    for (int i = 0; i < 3; i++) push_word(w[i]);
    push_word(enc(4'd15, 4'd0, 4'd0, 4'd0, 8'd0));
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_cnt++; if ({issue_valid, bus} !== {1'b1, w[i]}) $display("FAIL indep_issue%0d: got v=%b bus=%h want v=1 bus=%h", i, issue_valid, bus, w[i]); else pass_cnt++;
    end
    tick();
    check_cnt++; if ({issue_valid, halted, busy} !== 3'b010 || bus !== NOP_BUS) $display("FAIL halt_state: got v/halted/busy=%b bus=%h want 010 bus=%h", {issue_valid, halted, busy}, bus, NOP_BUS); else pass_cnt++;
    check_cnt++; if (issue_cnt !== 16'd3 || stall_cnt !== 16'd0) $display("FAIL indep_counts: got %0d/%0d want 3/0", issue_cnt, stall_cnt); else pass_cnt++;
    tick();
    check_cnt++; if (halted !== 1'b1) $display("FAIL halt_sticky: got %b want 1", halted); else pass_cnt++;
    pulse_start();
    check_cnt++; if ({halted, busy} !== 2'b01) $display("FAIL resume: got halted/busy=%b want 01", {halted, busy}); else pass_cnt++;
  endtask

  task automatic test_hazard();
    int b; bit ok;
    logic [23:0] wa, wm, ws;
    wa = enc(4'd0, 4'd3, 4'd5, 4'd10, 8'd1);
    wm = enc(4'd2, 4'd8, 4'd6, 4'd11, 8'd3);
    ws = enc(4'd1, 4'd10, 4'd4, 4'd12, 8'd2);
    do_reset();
    push_word(wa); push_word(ws);
    pulse_start();
    tick();
    check_cnt++; if ({issue_valid, bus} !== {1'b1, wa}) $display("FAIL haz_producer: got v=%b bus=%h want v=1 bus=%h", issue_valid, bus, wa); else pass_cnt++;
    wait_issue(10, b, ok);
    check_cnt++; if (!ok || bus !== ws) $display("FAIL haz_consumer: got ok=%b bus=%h want ok=1 bus=%h", ok, bus, ws); else pass_cnt++;
    check_cnt++; if (b !== EXP_B_ADJ) $display("FAIL haz_bubbles_adj: got %0d want %0d", b, EXP_B_ADJ); else pass_cnt++;
    check_cnt++; if (stall_cnt !== 16'(EXP_B_ADJ)) $display("FAIL haz_stall_cnt_adj: got %0d want %0d", stall_cnt, EXP_B_ADJ); else pass_cnt++;
    // One independent instruction between producer and consumer.
    do_reset();
    push_word(wa); push_word(wm); push_word(ws);
    pulse_start();
    tick(); tick();
    check_cnt++; if ({issue_valid, bus} !== {1'b1, wm}) $display("FAIL gap_middle: got v=%b bus=%h want v=1 bus=%h", issue_valid, bus, wm); else pass_cnt++;
    wait_issue(10, b, ok);
    check_cnt++; if (!ok || bus !== ws || b !== EXP_B_GAP) $display("FAIL gap_bubbles: got ok=%b bubbles=%0d bus=%h want ok=1 bubbles=%0d bus=%h", ok, b, bus, EXP_B_GAP, ws); else pass_cnt++;
    check_cnt++; if (stall_cnt !== 16'(EXP_B_GAP) || issue_cnt !== 16'd3) $display("FAIL gap_counts: got stall=%0d issue=%0d want %0d 3", stall_cnt, issue_cnt, EXP_B_GAP); else pass_cnt++;
  endtask

  task automatic test_nop_reg();
    int b; bit ok;
    logic [23:0] w0, w1;
    w0 = enc(4'd0, 4'd3, 4'd5, 4'd15, 8'd4);
    w1 = enc(4'd2, 4'd15, 4'd6, 4'd11, 8'd5);
    do_reset();
    push_word(w0); push_word(w1);
    pulse_start();
    tick();
    check_cnt++; if ({issue_valid, bus} !== {1'b1, w0}) $display("FAIL nopreg_first: got v=%b bus=%h want v=1 bus=%h", issue_valid, bus, w0); else pass_cnt++;
    wait_issue(10, b, ok);
    check_cnt++; if (!ok || b !== 0 || bus !== w1 || stall_cnt !== 16'd0) $display("FAIL nopreg_second: got ok=%b bubbles=%0d stall=%0d bus=%h want ok=1 0 0 bus=%h", ok, b, stall_cnt, bus, w1); else pass_cnt++;
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < 16; i++) push_word(enc(4'd0, 4'd1, 4'd2, 4'd4, 8'(i)));
    check_cnt++; if (ld_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", ld_ready); else pass_cnt++;
    push_word(enc(4'd0, 4'd1, 4'd2, 4'd4, 8'h99));
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      tick();
      check_cnt++; if ({issue_valid, bus} !== {1'b1, enc(4'd0, 4'd1, 4'd2, 4'd4, 8'(i))}) $display("FAIL full_issue%0d: got v=%b bus=%h want v=1 addr=%0d", i, issue_valid, bus, i); else pass_cnt++;
      if (i == 0) begin
        check_cnt++; if (ld_ready !== 1'b1) $display("FAIL full_ready_after_pop: got %b want 1", ld_ready); else pass_cnt++;
      end
    end
    tick();
    check_cnt++; if (issue_valid !== 1'b0 || issue_cnt !== 16'd16) $display("FAIL full_17th_dropped: got v=%b cnt=%0d want 0 16", issue_valid, issue_cnt); else pass_cnt++;
  endtask

  task automatic test_counter_wrap();
    int sent = 0;
    logic [23:0] w;
    w = enc(4'd0, 4'd1, 4'd2, 4'd3, 8'd0);
    do_reset();
    pulse_start();
    ld_data = w;
    for (int c = 0; c < 70000 && issue_cnt !== 16'hFFFF; c++) begin
      ld_valid = (sent < 65535);
      if (ld_valid && ld_ready) sent++;
      tick();
    end
    ld_valid = 1'b0;
    check_cnt++; if (issue_cnt !== 16'hFFFF) $display("FAIL cnt_max: got %0d want 65535", issue_cnt); else pass_cnt++;
    push_word(w);
    tick();
    check_cnt++; if (issue_valid !== 1'b1 || issue_cnt !== 16'd0) $display("FAIL cnt_wrap: got v=%b cnt=%0d want 1 0", issue_valid, issue_cnt); else pass_cnt++;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    test_reset();
    test_independent();
    test_hazard();
    test_nop_reg();
    test_fifo_full();
    test_counter_wrap();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
